// File: rtl/cpu_run_ctrl_if.sv
// Register-dump stream from the run controller to a display/UART consumer.
// The producer holds idx/data stable while valid is high and ready is low.
interface cpu_run_ctrl_if;
   logic        valid;
   logic [4:0]  idx;
   logic [31:0] data;
   logic        ready;
   logic        done;

   modport master (output valid, output idx, output data, output done, input ready);
   modport slave  (input valid, input idx, input data, input done, output ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Board-side run/debug controller for the pipelined cpu: reset stretch, free-run,
// single-step, halt, PC breakpoint, and a 32-register dump over the debug bus.
module cpu_run_ctrl #(
   parameter int unsigned RST_HOLD  = 4,
   parameter bit          AUTO_RUN  = 1'b0,
   parameter logic [15:0] DUMP_BASE = 16'h1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_req_i,
   input  logic                  step_req_i,
   input  logic                  halt_req_i,
   input  logic                  dump_req_i,
   input  logic                  bp_en_i,
   input  logic [31:0]           bp_addr_i,
   input  logic [31:0]           pc_i,
   input  logic [15:0]           sel_addr_i,
   input  logic [31:0]           chk_data_i,
   output logic [15:0]           chk_addr_o,
   output logic                  cpu_ce_o,
   output logic                  cpu_rst_o,
   output logic [2:0]            state_o,
   output logic [31:0]           cycle_cnt_o,
   cpu_run_ctrl_if.master        dump_bus
);

   localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   typedef enum logic [2:0] {
      S_RHOLD = 3'd0,
      S_HALT  = 3'd1,
      S_RUN   = 3'd2,
      S_STEP  = 3'd3,
      S_DUMP  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               bp_skip_q, bp_skip_d;
   logic [4:0]         idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [4:0]         widx_q, widx_d;
   logic [31:0]        data_q, data_d;
   logic               done_q, done_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               bp_hit;

   // bp_skip masks the match for the first RUN cycle so resuming at the breakpoint PC proceeds.
   assign bp_hit   = bp_en_i && (pc_i == bp_addr_i) && !bp_skip_q;
   assign cpu_ce_o = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      widx_d  = widx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_RHOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = AUTO_RUN ? S_RUN : S_HALT;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_HALT: begin
            if (halt_req_i) begin
               state_d = S_HALT;
            end else if (dump_req_i) begin
               state_d = S_DUMP;
               idx_d   = 5'd0;
               valid_d = 1'b0;
            end else if (step_req_i) begin
               state_d = S_STEP;
            end else if (run_req_i) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (halt_req_i || bp_hit) begin
               state_d = S_HALT;
            end
         end
         S_STEP: state_d = S_HALT;
         S_DUMP: begin
            // Alternate capture and accept cycles: the cycle with valid low lets chk_data settle.
            if (halt_req_i) begin
               state_d = S_HALT;
               valid_d = 1'b0;
            end else if (!valid_q) begin
               valid_d = 1'b1;
               widx_d  = idx_q;
               data_d  = chk_data_i;
            end else if (dump_bus.ready) begin
               valid_d = 1'b0;
               if (idx_q == 5'd31) begin
                  state_d = S_HALT;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: state_d = S_HALT;
      endcase
      bp_skip_d = (state_d == S_RUN) && (state_q != S_RUN);
      cnt_d     = cpu_ce_o ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RHOLD;
         hold_q    <= '0;
         bp_skip_q <= 1'b0;
         idx_q     <= 5'd0;
         valid_q   <= 1'b0;
         widx_q    <= 5'd0;
         data_q    <= 32'd0;
         done_q    <= 1'b0;
         cnt_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         bp_skip_q <= bp_skip_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         widx_q    <= widx_d;
         data_q    <= data_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cpu_rst_o      = (state_q == S_RHOLD);
   assign state_o        = state_q;
   assign cycle_cnt_o    = cnt_q;
   assign chk_addr_o     = (state_q == S_DUMP) ? (DUMP_BASE | {11'd0, idx_q}) : sel_addr_i;
   assign dump_bus.valid = valid_q;
   assign dump_bus.idx   = widx_q;
   assign dump_bus.data  = data_q;
   assign dump_bus.done  = done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset stretch, breakpoint/resume, stepping,
// request priority, full and stalled/aborted dumps, counter wrap, mid-dump reset.
module tb_cpu_run_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, dump_req = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'd0;
   logic [31:0] pc;
   logic [15:0] sel_addr = 16'h0042;
   logic [31:0] chk_data;
   logic [15:0] chk_addr;
   logic        cpu_ce, cpu_rst;
   logic [2:0]  state;
   logic [31:0] cycle_cnt;
   int          errors = 0;
   int          checks = 0;
   int          ce_seen = 0;
   int          done_seen = 0;
   int          ce_base;

   cpu_run_ctrl_if bus();

   cpu_run_ctrl #(.RST_HOLD(4), .AUTO_RUN(1'b0), .DUMP_BASE(16'h1000)) dut (
      .clk(clk), .rst(rst),
      .run_req_i(run_req), .step_req_i(step_req), .halt_req_i(halt_req), .dump_req_i(dump_req),
      .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .sel_addr_i(sel_addr),
      .chk_data_i(chk_data), .chk_addr_o(chk_addr), .cpu_ce_o(cpu_ce), .cpu_rst_o(cpu_rst),
      .state_o(state), .cycle_cnt_o(cycle_cnt), .dump_bus(bus)
   );

   always #5 clk = ~clk;

   // CPU model: pc advances by 4 per enabled cycle; debug bus returns 0xA000_0000+i for DUMP_BASE|i.
   always @(posedge clk) begin
      if (cpu_rst) pc <= 32'd0;
      else if (cpu_ce) pc <= pc + 32'd4;
   end
   always_comb begin
      chk_data = 32'hDEAD_BEEF;
      if (chk_addr[15:5] == 11'h080) chk_data = 32'hA000_0000 + {27'd0, chk_addr[4:0]};
   end
   always @(posedge clk) begin
      if (cpu_ce === 1'b1) ce_seen <= ce_seen + 1;
      if (bus.done === 1'b1) done_seen <= done_seen + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check_val("rst_ce", 32'(cpu_ce), 32'd0);
      check_val("rst_valid", 32'(bus.valid), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_data", bus.data, 32'd0);
      check_val("rst_idx", 32'(bus.idx), 32'd0);
      check_val("rst_cnt", cycle_cnt, 32'd0);
      check_val("rst_chk_addr", 32'(chk_addr), 32'h0042);
      tick();
      tick();
      rst = 1'b0;

      // Reset stretch: cpu_rst stays high for 4 cycles, run_req in RHOLD is ignored.
      for (int i = 0; i < 4; i++) begin
         check_val("hold_cpu_rst", 32'(cpu_rst), 32'd1);
         check_val("hold_state", 32'(state), 32'd0);
         run_req = (i == 0);
         tick();
      end
      run_req = 1'b0;
      check_val("post_hold_state", 32'(state), 32'd1);
      check_val("post_hold_cpu_rst", 32'(cpu_rst), 32'd0);
      check_val("post_hold_ce", 32'(cpu_ce), 32'd0);
      check_val("post_hold_cnt", cycle_cnt, 32'd0);
      $display("reset released: state=%0d cycle_cnt=%0d", state, cycle_cnt);

      // Breakpoint at 0x10: pc 0,4,8,12 execute, CPU stops with pc=0x10.
      bp_en = 1'b1;
      bp_addr = 32'h10;
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("bp_run_ce", 32'(cpu_ce), 32'd1);
         tick();
      end
      check_val("bp_pc", pc, 32'h10);
      check_val("bp_hit_ce", 32'(cpu_ce), 32'd0);
      tick();
      check_val("bp_state", 32'(state), 32'd1);
      check_val("bp_cnt", cycle_cnt, 32'd4);
      check_val("bp_halt_ce", 32'(cpu_ce), 32'd0);
      $display("breakpoint: pc=0x%08h cycle_cnt=%0d", pc, cycle_cnt);

      // Resume from the breakpoint PC without re-trapping, then halt.
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check_val("resume_ce", 32'(cpu_ce), 32'd1);
      tick();
      check_val("resume_pc", pc, 32'h14);
      check_val("resume_state", 32'(state), 32'd2);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check_val("halt_state", 32'(state), 32'd1);
      check_val("halt_cnt", cycle_cnt, 32'd6);
      check_val("halt_ce", 32'(cpu_ce), 32'd0);
      $display("resume+halt: pc=0x%08h cycle_cnt=%0d", pc, cycle_cnt);

      // Three single steps, 5 cycles apart; run_req during STEP is ignored.
      ce_base = ce_seen;
      for (int k = 0; k < 3; k++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         run_req = (k == 2);
         check_val("step_state", 32'(state), 32'd3);
         check_val("step_ce", 32'(cpu_ce), 32'd1);
         tick();
         run_req = 1'b0;
         check_val("step_back_state", 32'(state), 32'd1);
         check_val("step_back_ce", 32'(cpu_ce), 32'd0);
         $display("step %0d: cycle_cnt=%0d", k, cycle_cnt);
         tick(); tick(); tick();
      end
      check_val("step_cnt", cycle_cnt, 32'd9);
      check_val("step_ce_cycles", 32'(ce_seen - ce_base), 32'd3);

      // HALT priority: halt_req masks all, then dump_req beats step/run.
      halt_req = 1'b1; dump_req = 1'b1; step_req = 1'b1; run_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check_val("prio_halt_state", 32'(state), 32'd1);
      bus.ready = 1'b1;
      tick();
      dump_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
      check_val("prio_dump_state", 32'(state), 32'd4);
      check_val("dump_entry_valid", 32'(bus.valid), 32'd0);
      check_val("dump_entry_addr", 32'(chk_addr), 32'h1000);

      // Full dump with ready held high: one word every 2 cycles.
      for (int i = 0; i < 32; i++) begin
         tick();
         check_val("dump_valid", 32'(bus.valid), 32'd1);
         check_val("dump_idx", 32'(bus.idx), 32'(i));
         check_val("dump_data", bus.data, 32'hA000_0000 + 32'(i));
         check_val("dump_no_done", 32'(bus.done), 32'd0);
         $display("word idx=%0d data=0x%08h", bus.idx, bus.data);
         tick();
         check_val("dump_gap_valid", 32'(bus.valid), 32'd0);
         if (i < 31) check_val("dump_next_addr", 32'(chk_addr), 32'h1000 + 32'(i + 1));
      end
      check_val("dump_end_state", 32'(state), 32'd1);
      check_val("dump_done", 32'(bus.done), 32'd1);
      check_val("dump_end_addr", 32'(chk_addr), 32'h0042);
      tick();
      check_val("dump_done_pulse", 32'(bus.done), 32'd0);
      check_val("dump_done_count", 32'(done_seen), 32'd1);

      // Stall on idx 5 for 10 cycles, then abort with halt_req.
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); tick();
      end
      bus.ready = 1'b0;
      tick();
      check_val("stall_valid", 32'(bus.valid), 32'd1);
      check_val("stall_idx", 32'(bus.idx), 32'd5);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("stall_hold_data", bus.data, 32'hA000_0005);
         check_val("stall_hold_idx", 32'(bus.idx), 32'd5);
         check_val("stall_hold_valid", 32'(bus.valid), 32'd1);
      end
      $display("stalled word idx=%0d data=0x%08h", bus.idx, bus.data);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check_val("abort_valid", 32'(bus.valid), 32'd0);
      check_val("abort_state", 32'(state), 32'd1);
      check_val("abort_done", 32'(bus.done), 32'd0);
      tick();
      check_val("abort_done_count", 32'(done_seen), 32'd1);

      // Counter wrap: preset to all-ones, one step wraps it to zero.
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      check_val("wrap_preset", cycle_cnt, 32'hFFFF_FFFF);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      check_val("wrap_step_state", 32'(state), 32'd3);
      tick();
      check_val("wrap_cnt", cycle_cnt, 32'd0);
      $display("wrap step: cycle_cnt=%0d", cycle_cnt);

      // Asynchronous reset in the middle of a dump with a pending word.
      sel_addr = 16'h0BEE;
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      tick();
      check_val("pre_rst_valid", 32'(bus.valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_state", 32'(state), 32'd0);
      check_val("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check_val("mid_rst_ce", 32'(cpu_ce), 32'd0);
      check_val("mid_rst_valid", 32'(bus.valid), 32'd0);
      check_val("mid_rst_done", 32'(bus.done), 32'd0);
      check_val("mid_rst_data", bus.data, 32'd0);
      check_val("mid_rst_idx", 32'(bus.idx), 32'd0);
      check_val("mid_rst_cnt", cycle_cnt, 32'd0);
      check_val("mid_rst_chk_addr", 32'(chk_addr), 32'h0BEE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
